uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver that pairs with the team's UART transmitter. It decodes 8N1 frames (8 data bits, no parity, 1 stop bit), sent LSB first, from an asynchronous `rx` line and presents each byte with a one-cycle valid strobe. It sits between the board RX pin and the byte-level consumer, such as a command decoder or FIFO. Bit timing uses the same clocks-per-bit parameter as the transmitter, so a loopback link needs no adjustment.

## Interface
- BAUD_VAL, 9, clock cycles per bit; must be ≥ 4.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- rx  in  1  asynchronous serial input; idle high.
- data_out  out  8  last good byte received; holds its value until the next good frame.
- data_valid  out  1  one-cycle pulse; data_out is new in that same cycle.
- rx_active  out  1  high from start-bit detection until the end of CLEANUP.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- parity_err  out  1  one-cycle pulse on parity mismatch; constant 0 unless the parity feature is compiled in.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rxs`. All decisions use `rxs` only.
- H = (BAUD_VAL-1)/2, using integer division. The bit counter is 32 bits wide and counts 0..BAUD_VAL-1.
- States:
  - IDLE → START when `rxs`==0 and the receiver is armed.
  - START: count H cycles, then sample `rxs`.
    - Sample is 0: clear the counter and go to RXDATA.
    - Sample is 1: treat as a glitch and return to IDLE. No error flag is raised.
  - RXDATA: count BAUD_VAL cycles, then sample into `shift[bit_index]`, bit_index 0..7. After bit 7, go to PARITY or STOP.
  - PARITY (macro only): count BAUD_VAL cycles, sample, compare, then go to STOP.
  - STOP: count BAUD_VAL cycles, then sample.
    - Sample is 1: load data_out from `shift` and pulse data_valid.
    - Sample is 0: pulse frame_err; data_out is unchanged.
    - In both cases go to CLEANUP.
  - CLEANUP: one cycle, then go to IDLE. rx_active drops on the exit from CLEANUP.
- Arming:
  - The receiver is armed after reset.
  - After a frame error it is disarmed. It stays in IDLE until `rxs`==1 has been seen, then re-arms. A break condition (line held low) produces exactly one frame_err.
- A parity error still delivers the byte: data_valid and parity_err pulse together.
- Reset mid-frame: abandon the frame at once. There is no data_valid or error pulse, and the state is IDLE, armed, on the next cycle.

## Timing
- Reset values: data_out=0x00, data_valid=0, rx_active=0, frame_err=0, parity_err=0. The state is IDLE and the synchronizer flops are 1.
- Synchronizer latency: 2 cycles from the pin to `rxs`.
- Let t0 be the first cycle in which IDLE sees `rxs`==0.
  - rx_active is high from t0+1.
  - The sample of data bit k is taken at t0 + H + (k+1)·BAUD_VAL.
  - The stop sample is taken at t0 + H + 9·BAUD_VAL, or +10·BAUD_VAL with parity.
- data_valid and frame_err are registered and assert the cycle after the stop sample.
- A new start bit may be detected on the first IDLE cycle after CLEANUP. This absorbs back-to-back frames whose stop bit is shortened by up to BAUD_VAL−H−2 cycles.

## Configuration
- UART_RX_PARITY_EN
  - Defined: a PARITY state is inserted after bit 7. Parity is even: the XOR of the 8 data bits plus the parity bit must be 0. parity_err pulses in the same cycle as data_valid on mismatch. The frame is 11 bits.
  - Undefined: there is no PARITY state, parity_err is tied to 0, and the frame is 10 bits.
- The transmitter must be built with the matching setting.

## Structure
- Shared package `uart_pkg`: 3-bit state encodings (IDLE, START, DATA, PARITY, STOP, CLEANUP), DATA_BITS=8, and a default BAUD_VAL. These are shared with the transmitter.
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer, whose reset value is 1.

## Test plan
- Loopback with the transmitter, BAUD_VAL=9: send 0xA5, then 0x00, then 0xFF. Required: data_out takes each value in order, with exactly 3 data_valid pulses and no errors.
- Low glitch of 2 cycles on idle rx: no state leaves IDLE beyond START, no data_valid, and rx_active falls within H+3 cycles.
- Frame 0x3C with the stop bit forced low, then rx held low for 40 cycles, then high: exactly one frame_err, data_out unchanged, and no new frame until after rx returns high.
- Reset asserted during bit 4 of 0x81, then a clean 0x42 sent: no pulse for the aborted frame; data_valid with data_out=0x42.
- Back-to-back frames 0x55 and 0xAA, with the stop bit shortened to BAUD_VAL−2 cycles: both bytes are received correctly.
- With UART_RX_PARITY_EN defined, send 0x07 with a wrong parity bit: data_valid, parity_err=1, data_out=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: state encodings,
// data width and the default clocks-per-bit value.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_PARITY  = 3'd3,
      ST_STOP    = 3'd4,
      ST_CLEANUP = 3'd5
   } uart_state_e;

   localparam int DATA_BITS        = 8;
   localparam int BAUD_VAL_DEFAULT = 9;

   // Offset from the start-bit edge to the middle of a bit period.
   function automatic int half_bit(input int baud);
      return (baud - 1) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; both flops reset to the
// idle line level so a reset never looks like a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic rx_i,
   output logic rxs_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
      end
   end

   assign rxs_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, BAUD_VAL clocks per bit.
// Define UART_RX_PARITY_EN to insert an even-parity bit after data bit 7.
//
// state      | meaning
// IDLE       | waiting for rxs low while armed; re-arms on rxs high
// START      | half-bit wait, then confirm the start bit
// DATA       | one bit period per data bit, sampled at the bit centre
// PARITY     | parity bit sample (parity build only)
// STOP       | stop bit sample, deliver byte or flag frame error
// CLEANUP    | single cycle before returning to IDLE
module uart_receiver
   import uart_pkg::*;
#(
   parameter int BAUD_VAL = BAUD_VAL_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       rx_active,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int          H        = half_bit(BAUD_VAL);
   localparam logic [31:0] HALF_END = 32'(H - 1);
   localparam logic [31:0] BIT_END  = 32'(BAUD_VAL - 1);

   logic                 rxs;
   uart_state_e          state_q;
   logic [31:0]          cnt_q;
   logic [2:0]           bit_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_out_q;
   logic                 armed_q;
   logic                 data_valid_q;
   logic                 frame_err_q;
   logic                 rx_active_q;
`ifdef UART_RX_PARITY_EN
   logic                 parity_bad_q;
   logic                 parity_err_q;
`endif

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .rx_i  (rx),
      .rxs_o (rxs)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_out_q   <= '0;
         armed_q      <= 1'b1;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_active_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               cnt_q     <= '0;
               bit_idx_q <= '0;
               // After a frame error the line must go high before a new start counts.
               if (!armed_q) begin
                  if (rxs) armed_q <= 1'b1;
               end else if (!rxs) begin
                  state_q     <= ST_START;
                  rx_active_q <= 1'b1;
               end
            end
            ST_START: begin
               if (cnt_q == HALF_END) begin
                  cnt_q <= '0;
                  if (rxs) begin
                     state_q     <= ST_IDLE;
                     rx_active_q <= 1'b0;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            ST_DATA: begin
               if (cnt_q == BIT_END) begin
                  cnt_q              <= '0;
                  shift_q[bit_idx_q] <= rxs;
                  bit_idx_q          <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (cnt_q == BIT_END) begin
                  cnt_q        <= '0;
                  parity_bad_q <= (^shift_q) ^ rxs;
                  state_q      <= ST_STOP;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
`endif
            ST_STOP: begin
               if (cnt_q == BIT_END) begin
                  cnt_q   <= '0;
                  state_q <= ST_CLEANUP;
                  if (rxs) begin
                     data_out_q   <= shift_q;
                     data_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err_q <= parity_bad_q;
`endif
                  end else begin
                     frame_err_q <= 1'b1;
                     armed_q     <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            ST_CLEANUP: begin
               state_q     <= ST_IDLE;
               rx_active_q <= 1'b0;
            end
            default: begin
               state_q     <= ST_IDLE;
               rx_active_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign rx_active  = rx_active_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames plus hand-written
// glitch, break, mid-frame reset and parity sequences, checked via a scoreboard.
module tb_uart_receiver;

   localparam int B = 9;
   localparam int H = (B - 1) / 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       rx_active;
   logic       frame_err;
   logic       parity_err;

   int checks = 0;
   int failures = 0;
   int dv_count = 0;
   int exp_dv_count = 0;
   logic [7:0] last_good = 8'h00;

   typedef struct {
      bit         is_fe;
      logic [7:0] data;
      bit         perr;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [7:0] data;
      int         stop_len;
      int         idle_after;
      logic [7:0] exp_data;
   } vec_t;
   vec_t vecs[6];

   uart_receiver #(.BAUD_VAL(B)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .rx_active  (rx_active),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard: every strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!reset && (data_valid || frame_err)) begin
         if (data_valid) dv_count++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse dv=%0b fe=%0b data_out=%0h", data_valid, frame_err, data_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_dv", 32'(data_valid), 32'(!e.is_fe));
            chk("pulse_fe", 32'(frame_err), 32'(e.is_fe));
            chk("pulse_data_out", 32'(data_out), 32'(e.data));
            chk("pulse_parity_err", 32'(parity_err), 32'(e.perr));
         end
      end
   end

   task automatic expect_byte(input logic [7:0] b, input bit perr);
      exp_q.push_back('{is_fe: 1'b0, data: b, perr: perr});
      last_good = b;
      exp_dv_count++;
   endtask

   task automatic expect_fe();
      exp_q.push_back('{is_fe: 1'b1, data: last_good, perr: 1'b0});
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len, input bit par_bad);
      rx = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (B) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_bad;
      repeat (B) @(negedge clk);
`endif
      rx = stop_bit;
      repeat (stop_len) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      bit   saw_active;
      logic [7:0] b;

      vecs[0] = '{data: 8'hA5, stop_len: B,     idle_after: 3, exp_data: 8'hA5};
      vecs[1] = '{data: 8'h00, stop_len: B,     idle_after: 3, exp_data: 8'h00};
      vecs[2] = '{data: 8'hFF, stop_len: B,     idle_after: 3, exp_data: 8'hFF};
      vecs[3] = '{data: 8'h55, stop_len: B - 2, idle_after: 0, exp_data: 8'h55};
      vecs[4] = '{data: 8'hAA, stop_len: B - 2, idle_after: 0, exp_data: 8'hAA};
      vecs[5] = '{data: 8'h3E, stop_len: B,     idle_after: 3, exp_data: 8'h3E};

      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_data_out", 32'(data_out), 32'h00);
      chk("reset_data_valid", 32'(data_valid), 32'h0);
      chk("reset_rx_active", 32'(rx_active), 32'h0);
      chk("reset_frame_err", 32'(frame_err), 32'h0);
      chk("reset_parity_err", 32'(parity_err), 32'h0);
      idle(3);

      // Table frames, including back-to-back frames with shortened stop bits.
      for (int v = 0; v < 6; v++) begin
         expect_byte(vecs[v].exp_data, 1'b0);
         send_frame(vecs[v].data, 1'b1, vecs[v].stop_len, 1'b0);
         if (vecs[v].idle_after > 0) idle(vecs[v].idle_after);
      end
      idle(4);
      wait_drain("table", 40);
      chk("table_last_data_out", 32'(data_out), 32'h3E);

      // Two-cycle low glitch: START is entered then abandoned.
      saw_active = 1'b0;
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      for (int i = 0; i < H + 6; i++) begin
         if (rx_active) saw_active = 1'b1;
         @(negedge clk);
      end
      chk("glitch_saw_active", 32'(saw_active), 32'h1);
      chk("glitch_active_dropped", 32'(rx_active), 32'h0);
      chk("glitch_data_out", 32'(data_out), 32'h3E);
      idle(2 * B);

      // Stop bit low followed by a break: one frame error, byte kept.
      expect_fe();
      send_frame(8'h3C, 1'b0, B, 1'b0);
      repeat (40) @(negedge clk);
      chk("break_rx_active", 32'(rx_active), 32'h0);
      chk("break_data_out", 32'(data_out), 32'h3E);
      wait_drain("break", 5);
      idle(3);
      expect_byte(8'h96, 1'b0);
      send_frame(8'h96, 1'b1, B, 1'b0);
      idle(4);
      wait_drain("rearm", 40);

      // Reset partway through bit 4 of 0x81, then a clean 0x42.
      b = 8'h81;
      rx = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (B) @(negedge clk);
      end
      rx = b[4];
      repeat (H) @(negedge clk);
      reset = 1'b1;
      rx = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      last_good = 8'h00;
      @(negedge clk);
      chk("midreset_rx_active", 32'(rx_active), 32'h0);
      chk("midreset_data_out", 32'(data_out), 32'h00);
      idle(12 * B);
      chk("midreset_quiet", 32'(rx_active), 32'h0);
      expect_byte(8'h42, 1'b0);
      send_frame(8'h42, 1'b1, B, 1'b0);
      idle(4);
      wait_drain("after_reset", 40);
      chk("after_reset_data_out", 32'(data_out), 32'h42);

`ifdef UART_RX_PARITY_EN
      expect_byte(8'h07, 1'b1);
      send_frame(8'h07, 1'b1, B, 1'b1);
      idle(4);
      wait_drain("parity", 40);
      chk("parity_data_out", 32'(data_out), 32'h07);
`endif

      idle(5);
      chk("valid_count", 32'(dv_count), 32'(exp_dv_count));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
